// File: rtl/pico_mips.sv
// pico_mips: single-cycle 16-bit processor running a fixed ROM program (2-D affine transform of switch operands).
// Optional define PICOMIPS_SW_SYNC_EN routes SW[8:0] through a 2-flop synchronizer before use.
module pico_mips #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 6,
    parameter int INSTR_W = 16
) (
    input  logic       Clock,
    input  logic [9:0] SW,
    output logic [7:0] LED
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LDSW  = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_ADDI  = 4'd4,
        OP_MULI  = 4'd5,
        OP_ASR   = 4'd6,
        OP_OUT   = 4'd7,
        OP_WAITH = 4'd8,
        OP_WAITL = 4'd9,
        OP_JMP   = 4'd10
    } opcode_t;

    function automatic logic [INSTR_W-1:0] enc(input opcode_t op, input logic [1:0] rd,
                                               input logic [1:0] rs, input logic [7:0] imm);
        enc = {op, rd, rs, imm};
    endfunction

    logic [PC_W-1:0]          pc;
    logic [PC_W-1:0]          pc_next;
    logic [INSTR_W-1:0]       instr;
    logic signed [DATA_W-1:0] regs [4];
    logic [8:0]               sw_in;

`ifdef PICOMIPS_SW_SYNC_EN
    logic [8:0] sync_a;
    logic [8:0] sync_b;

    always_ff @(posedge Clock) begin
        if (!SW[9]) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= SW[8:0];
            sync_b <= sync_a;
        end
    end

    assign sw_in = sync_b;
`else
    assign sw_in = SW[8:0];
`endif

    // x2 = floor((3x + 2y + 80)/4) and y2 = floor((-2x + 3y - 80)/4), one shift per result
    always_comb begin
        instr = enc(OP_NOP, 2'd0, 2'd0, 8'h00);
        case (pc)
            PC_W'(0):  instr = enc(OP_WAITH, 2'd0, 2'd0, 8'h00);
            PC_W'(1):  instr = enc(OP_LDSW,  2'd1, 2'd0, 8'h00);
            PC_W'(2):  instr = enc(OP_WAITL, 2'd0, 2'd0, 8'h00);
            PC_W'(3):  instr = enc(OP_WAITH, 2'd0, 2'd0, 8'h00);
            PC_W'(4):  instr = enc(OP_LDSW,  2'd2, 2'd0, 8'h00);
            PC_W'(5):  instr = enc(OP_WAITL, 2'd0, 2'd0, 8'h00);
            PC_W'(6):  instr = enc(OP_MULI,  2'd3, 2'd1, 8'h03);
            PC_W'(7):  instr = enc(OP_MULI,  2'd0, 2'd2, 8'h02);
            PC_W'(8):  instr = enc(OP_ADD,   2'd3, 2'd0, 8'h00);
            PC_W'(9):  instr = enc(OP_ADDI,  2'd3, 2'd0, 8'h50);
            PC_W'(10): instr = enc(OP_ASR,   2'd3, 2'd0, 8'h02);
            PC_W'(11): instr = enc(OP_OUT,   2'd0, 2'd3, 8'h00);
            PC_W'(12): instr = enc(OP_MULI,  2'd3, 2'd2, 8'h03);
            PC_W'(13): instr = enc(OP_MULI,  2'd0, 2'd1, 8'hFE);
            PC_W'(14): instr = enc(OP_ADD,   2'd3, 2'd0, 8'h00);
            PC_W'(15): instr = enc(OP_ADDI,  2'd3, 2'd0, 8'hB0);
            PC_W'(16): instr = enc(OP_ASR,   2'd3, 2'd0, 8'h02);
            PC_W'(17): instr = enc(OP_WAITH, 2'd0, 2'd0, 8'h00);
            PC_W'(18): instr = enc(OP_OUT,   2'd0, 2'd3, 8'h00);
            PC_W'(19): instr = enc(OP_WAITL, 2'd0, 2'd0, 8'h00);
            PC_W'(20): instr = enc(OP_JMP,   2'd0, 2'd0, 8'h00);
            default:   instr = enc(OP_NOP,   2'd0, 2'd0, 8'h00);
        endcase
    end

    opcode_t                  op;
    logic [1:0]               rd;
    logic [1:0]               rs;
    logic [7:0]               imm8;
    logic signed [DATA_W-1:0] imm;
    logic signed [DATA_W-1:0] rd_val;
    logic signed [DATA_W-1:0] rs_val;
    logic signed [DATA_W-1:0] wr_data;
    logic                     wr_en;
    logic                     led_en;

    assign op     = opcode_t'(instr[15:12]);
    assign rd     = instr[11:10];
    assign rs     = instr[9:8];
    assign imm8   = instr[7:0];
    assign imm    = {{(DATA_W-8){imm8[7]}}, imm8};
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];

    always_comb begin
        pc_next = pc + 1'b1;
        wr_en   = 1'b0;
        wr_data = rd_val;
        led_en  = 1'b0;
        case (op)
            OP_LDSW: begin
                wr_en   = 1'b1;
                wr_data = {{(DATA_W-8){sw_in[7]}}, sw_in[7:0]};
            end
            OP_ADD: begin
                wr_en   = 1'b1;
                wr_data = rd_val + rs_val;
            end
            OP_SUB: begin
                wr_en   = 1'b1;
                wr_data = rd_val - rs_val;
            end
            OP_ADDI: begin
                wr_en   = 1'b1;
                wr_data = rd_val + imm;
            end
            // Only the low DATA_W bits of the signed product are kept
            OP_MULI: begin
                wr_en   = 1'b1;
                wr_data = rs_val * imm;
            end
            OP_ASR: begin
                wr_en   = 1'b1;
                wr_data = rd_val >>> imm8[3:0];
            end
            OP_OUT:   led_en = 1'b1;
            OP_WAITH: if (!sw_in[8]) pc_next = pc;
            OP_WAITL: if (sw_in[8]) pc_next = pc;
            OP_JMP:   pc_next = imm8[PC_W-1:0];
            default:  ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!SW[9]) begin
            pc  <= '0;
            LED <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            pc <= pc_next;
            if (wr_en) regs[rd] <= wr_data;
            if (led_en) LED <= rs_val[7:0];
        end
    end

endmodule

// File: tb/tb_pico_mips.sv
// tb_pico_mips: randomized handshake sequences against an arithmetic reference model.
// A scoreboard queue of timed LED expectations is drained by an independent monitor.
module tb_pico_mips;

`ifdef PICOMIPS_SW_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       Clock = 1'b0;
    logic [9:0] SW;
    logic [7:0] LED;

    pico_mips dut (
        .Clock(Clock),
        .SW   (SW),
        .LED  (LED)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string      name;
        logic [7:0] value;
        int         due;
    } expect_t;

    expect_t sb[$];
    int      cyc    = 0;
    int      n_vec  = 0;
    int      n_fail = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Reference model: floor of the integer-scaled sum, then wrap to 8 bits
    function automatic int floor_div4(input int n);
        int q;
        q = n / 4;
        if ((n % 4 != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [7:0] ref_x2(input int x, input int y);
        int r;
        r = floor_div4(3 * x + 2 * y + 80);
        return r[7:0];
    endfunction

    function automatic logic [7:0] ref_y2(input int x, input int y);
        int r;
        r = floor_div4(-2 * x + 3 * y - 80);
        return r[7:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic pushExpect(input string name, input logic [7:0] value, input int delay);
        expect_t e;
        e.name  = name;
        e.value = value;
        e.due   = cyc + delay;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        n_vec++;
        if (LED !== e.value) begin
            n_fail++;
            $display("[TB] FAIL %s: LED=0x%02h (%0d) expected 0x%02h (%0d)",
                     e.name, LED, $signed(LED), e.value, $signed(e.value));
        end
    endtask

    task automatic pulseOperand(input int v);
        SW[7:0] = 8'(v);
        tick(4);
        SW[8] = 1'b1;
        tick(4);
        SW[8] = 1'b0;
    endtask

    task automatic applyStimulus(input int x, input int y);
        logic [7:0] ex;
        logic [7:0] ey;
        string      tag;
        ex  = ref_x2(x, y);
        ey  = ref_y2(x, y);
        tag = $sformatf("(%0d,%0d)", x, y);
        pulseOperand(x);
        tick(4 + SYNC_LAT);
        pulseOperand(y);
        pushExpect({"x2", tag}, ex, 8 + SYNC_LAT);
        tick(20 + SYNC_LAT);
        pushExpect({"x2_hold", tag}, ex, 0);
        SW[8] = 1'b1;
        pushExpect({"y2", tag}, ey, 2 + SYNC_LAT);
        tick(4 + SYNC_LAT);
        SW[8] = 1'b0;
        tick(4 + SYNC_LAT);
    endtask

    initial begin
        expect_t e;
        forever begin
            @(negedge Clock);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int dx[7] = '{4, 40, 20, 11, 4, -128, 127};
        int dy[7] = '{6, 21, 55, 2, 6, 127, -128};
        int x;
        int y;

        SW = 10'd0;
        tick(3);
        pushExpect("reset_led", 8'h00, 0);
        SW[9] = 1'b1;
        tick(5);
        pushExpect("idle_led_a", 8'h00, 0);
        tick(5);
        pushExpect("idle_led_b", 8'h00, 0);

        for (int i = 0; i < 7; i++) applyStimulus(dx[i], dy[i]);

        // Reset in the middle of a transaction, after x1 has been loaded
        applyStimulus(4, 6);
        pulseOperand(33);
        tick(2);
        SW[9] = 1'b0;
        pushExpect("mid_reset_led", 8'h00, 1);
        tick(3);
        SW[9] = 1'b1;
        tick(4);
        pushExpect("post_reset_led", 8'h00, 0);
        applyStimulus(4, 6);

        for (int i = 0; i < 16; i++) begin
            x = int'($urandom_range(255)) - 128;
            y = int'($urandom_range(255)) - 128;
            applyStimulus(x, y);
        end

        for (int i = 0; i < 100 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            n_fail++;
            $display("[TB] FAIL drain: pending=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
